// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding word-fetch, a single output
// register toward decode, redirect handling and a wait-cycle counter.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_cs,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [15:0] wait_cycles
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic [15:0] wait_q, wait_d;
    logic        slot_free;
    logic        capture;
    logic        unused_rpc;

    assign unused_rpc = ^redirect_pc[1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        ifpc_d    = ifpc_q;
        valid_d   = valid_q;
        wait_d    = wait_q;
        slot_free = !valid_q || !stall;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                capture = imem_ack && slot_free && !redirect;
                // Redirect wins over everything, including a same-cycle ack.
                if (redirect) begin
                    pc_d    = {redirect_pc[31:2], 2'b00};
                    valid_d = 1'b0;
                end else if (capture) begin
                    inst_d  = imem_data;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end else if (valid_q && !stall) begin
                    valid_d = 1'b0;
                end
                if (!capture && wait_q != 16'hFFFF) begin
                    wait_d = wait_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            ifpc_q  <= 32'h0;
            valid_q <= 1'b0;
            wait_q  <= 16'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            wait_q  <= wait_d;
        end
    end

    assign imem_cs     = (state_q == FETCH);
    assign imem_addr   = pc_q[11:2];
    assign if_valid    = valid_q;
    assign if_inst     = inst_q;
    assign if_pc       = ifpc_q;
    assign wait_cycles = wait_q;

endmodule
